// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M execution unit.
// Multiplies go through a registered multiplier stage held for MUL_LAT cycles.
// Divides use an iterative restoring divider producing one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the divider and finish in one cycle.
module muldiv_unit #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            CLK,
    input  logic            RESETn,
    input  logic            START,
    input  logic            KILL,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    output logic            BUSY,
    output logic            VALID,
    output logic [XLEN-1:0] RESULT
);

    localparam int CMAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] result_q, result_d;

    // Operand decode for a newly requested divide
    logic            in_sdiv, d1_neg, d2_neg, in_ovf;
    logic [XLEN-1:0] d1_mag, d2_mag;

    // Multiplier datapath
    logic            ma_sgn, mb_sgn;
    logic [XLEN:0]   mul_a, mul_b;
    logic [2*XLEN-1:0] prod;

    // One restoring-division step
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff, div_rem, div_quo;
    logic            ge;

    // Combinational datapaths: accept-time decode, product, divider step
    always_comb begin
        in_sdiv = ~FUNCT3[0];
        d1_neg  = in_sdiv & DATA1[XLEN-1];
        d2_neg  = in_sdiv & DATA2[XLEN-1];
        d1_mag  = d1_neg ? ('0 - DATA1) : DATA1;
        d2_mag  = d2_neg ? ('0 - DATA2) : DATA2;
        in_ovf  = in_sdiv & (DATA1 == MIN_NEG) & (DATA2 == '1);

        ma_sgn  = (op_q == 3'b000) | (op_q == 3'b001) | (op_q == 3'b010);
        mb_sgn  = (op_q == 3'b000) | (op_q == 3'b001);
        mul_a   = {ma_sgn & a_q[XLEN-1], a_q};
        mul_b   = {mb_sgn & b_q[XLEN-1], b_q};
        // Extending both (XLEN+1)-bit operands to 2*XLEN keeps the truncated product exact
        prod    = {{(XLEN-1){mul_a[XLEN]}}, mul_a} * {{(XLEN-1){mul_b[XLEN]}}, mul_b};

        shifted = {rem_q, quo_q[XLEN-1]};
        ge      = (shifted >= {1'b0, b_q});
        // When ge holds the true difference is below b_q, so XLEN bits suffice
        diff    = shifted[XLEN-1:0] - b_q;
        div_rem = ge ? diff : shifted[XLEN-1:0];
        div_quo = {quo_q[XLEN-2:0], ge};
    end

    // Next-state logic: FSM sequencing, operand capture and result update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (START && !KILL) begin
                    op_d = FUNCT3;
                    if (!FUNCT3[2]) begin
                        a_d     = DATA1;
                        b_d     = DATA2;
                        cnt_d   = CW'(MUL_LAT - 1);
                        state_d = S_MUL;
                    end else if (DATA2 == '0) begin
                        result_d = FUNCT3[1] ? DATA1 : '1;
                        state_d  = S_DONE;
                    end else if (in_ovf) begin
                        result_d = FUNCT3[1] ? '0 : DATA1;
                        state_d  = S_DONE;
                    end else begin
                        quo_d   = d1_mag;
                        b_d     = d2_mag;
                        rem_d   = '0;
                        qneg_d  = d1_neg ^ d2_neg;
                        rneg_d  = d1_neg;
                        cnt_d   = CW'(XLEN - 1);
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    result_d = (op_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                rem_d = div_rem;
                quo_d = div_quo;
                if (cnt_q == '0) begin
                    // Sign correction is folded into the final iteration's write-back
                    if (op_q[1]) result_d = rneg_q ? ('0 - div_rem) : div_rem;
                    else         result_d = qneg_q ? ('0 - div_quo) : div_quo;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins over any completion in the same cycle
        if (KILL && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign BUSY   = (state_q != S_IDLE);
    assign VALID  = (state_q == S_DONE);
    assign RESULT = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model (XLEN=32, MUL_LAT=2).
module tb_muldiv_unit;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;

    logic            CLK = 1'b0;
    logic            RESETn;
    logic            START;
    logic            KILL;
    logic [2:0]      FUNCT3;
    logic [XLEN-1:0] DATA1, DATA2;
    logic            BUSY, VALID;
    logic [XLEN-1:0] RESULT;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int kcyc   = 0;

    muldiv_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .START  (START),
        .KILL   (KILL),
        .FUNCT3 (FUNCT3),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .BUSY   (BUSY),
        .VALID  (VALID),
        .RESULT (RESULT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: RISC-V M-extension semantics in plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, ua, ub, p;
        longint unsigned pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = longint'(ua) * longint'(ub); return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return MUL_LAT + 1;
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Present a request at the falling edge; it is accepted on the next rising edge
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        START  = 1'b1;
        FUNCT3 = f;
        DATA1  = a;
        DATA2  = b;
        @(posedge CLK);
        #1;
        kcyc   = cyc;
        START  = 1'b0;
        FUNCT3 = 3'($urandom);
        DATA1  = $urandom;
        DATA2  = $urandom;
    endtask

    // Wait (bounded) for VALID, check latency/result, then check the following idle cycle
    task automatic wait_check(input string tag, input logic [31:0] exp, input int lat);
        int n = 0;
        while (VALID !== 1'b1 && n < 60) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check({tag, "_lat"}, 32'(cyc - kcyc + 1), 32'(lat));
        check({tag, "_res"}, RESULT, exp);
        @(posedge CLK);
        #1;
        check({tag, "_vld_low"}, {31'b0, VALID}, 32'd0);
        check({tag, "_idle"}, {31'b0, BUSY}, 32'd0);
        check({tag, "_hold"}, RESULT, exp);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        issue(f, a, b);
        wait_check(tag, exp, model_lat(f, a, b));
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t dir[12];

    initial begin
        logic [31:0] prev;
        logic        saw;
        logic [2:0]  f;
        logic [31:0] a, b;

        dir[0]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        dir[1]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        dir[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        dir[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        dir[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        dir[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        dir[6]  = '{3'd5, 32'd100,       32'd7,         32'd14};
        dir[7]  = '{3'd7, 32'd100,       32'd7,         32'd2};
        dir[8]  = '{3'd5, 32'd7,         32'd0,         32'hFFFF_FFFF};
        dir[9]  = '{3'd6, 32'd7,         32'd0,         32'd7};
        dir[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        dir[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

        RESETn = 1'b0;
        START  = 1'b0;
        KILL   = 1'b0;
        FUNCT3 = '0;
        DATA1  = '0;
        DATA2  = '0;
        repeat (3) @(negedge CLK);
        check("rst_busy",   {31'b0, BUSY},  32'd0);
        check("rst_valid",  {31'b0, VALID}, 32'd0);
        check("rst_result", RESULT,         32'd0);
        RESETn = 1'b1;

        // Directed vectors with hand-derived expectations
        for (int i = 0; i < 12; i++)
            run_op($sformatf("dir%0d", i), dir[i].f, dir[i].a, dir[i].b, dir[i].exp);

        // Randomized operations, including forced zero divisor and overflow operands
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), f, a, b, model(f, a, b));
        end

        // Flush mid-divide, then a new request in the cycle right after
        prev = RESULT;
        issue(3'd4, 32'd1000, 32'd3);
        repeat (5) @(negedge CLK);
        KILL = 1'b1;
        @(posedge CLK);
        #1;
        KILL = 1'b0;
        check("kill_busy",   {31'b0, BUSY},  32'd0);
        check("kill_valid",  {31'b0, VALID}, 32'd0);
        check("kill_result", RESULT,         prev);
        run_op("after_kill", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0));

        // KILL together with START while idle drops the request
        prev = RESULT;
        @(negedge CLK);
        START = 1'b1; KILL = 1'b1; FUNCT3 = 3'd5; DATA1 = 32'd9; DATA2 = 32'd0;
        @(posedge CLK);
        #1;
        START = 1'b0; KILL = 1'b0;
        check("killstart_busy", {31'b0, BUSY}, 32'd0);
        saw = 1'b0;
        repeat (5) begin @(posedge CLK); #1; if (VALID) saw = 1'b1; end
        check("killstart_novalid", {31'b0, saw}, 32'd0);
        check("killstart_result", RESULT, prev);

        // START while busy is ignored and not queued
        issue(3'd5, 32'd100, 32'd7);
        repeat (3) @(negedge CLK);
        START = 1'b1; FUNCT3 = 3'd0; DATA1 = 32'd3; DATA2 = 32'd5;
        @(negedge CLK);
        START = 1'b0;
        wait_check("busy_start", 32'd14, XLEN + 1);
        saw = 1'b0;
        repeat (5) begin @(posedge CLK); #1; if (BUSY || VALID) saw = 1'b1; end
        check("busy_start_noqueue", {31'b0, saw}, 32'd0);

        // Reset in the middle of a divide
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        repeat (10) @(negedge CLK);
        RESETn = 1'b0;
        #1;
        check("midrst_busy",   {31'b0, BUSY},  32'd0);
        check("midrst_valid",  {31'b0, VALID}, 32'd0);
        check("midrst_result", RESULT,         32'd0);
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        saw = 1'b0;
        repeat (40) begin @(posedge CLK); #1; if (VALID) saw = 1'b1; end
        check("midrst_novalid", {31'b0, saw}, 32'd0);
        check("midrst_idle", {31'b0, BUSY}, 32'd0);

        run_op("post_rst", 3'd7, 32'd100, 32'd7, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
